score_display_ctrl: RTL and testbench

Score sequencer and display scheduler for the four-digit seven-segment path. It owns the BCD score and best-score registers and adds the bar speed to the score on each catch event. On a miss it runs the game-over display sequence: blink the final score, then show the best score, then clear the score. Its digit bus feeds the existing per-digit decoders and scan multiplexer, replacing the direct score counter in front of them.

---
 rtl/score_display_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_score_display_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_display_ctrl.sv
// Score sequencer and display scheduler for the four-digit seven-segment path:
// BCD score/best registers, digit-serial catch adder and game-over blink/best sequence.
module score_display_ctrl #(
  parameter int BLINK_HALF  = 25_000_000,
  parameter int BLINK_COUNT = 3,
  parameter int BEST_HOLD   = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        get,
  input  logic        lose,
  input  logic [3:0]  bar_move_speed,
  output logic [15:0] score,
  output logic [15:0] best,
  output logic [15:0] disp_digits,
  output logic        disp_blank,
  output logic        busy,
  output logic        game_over,
  output logic        new_best
);

  typedef enum logic [2:0] {
    S_PLAY      = 3'd0,
    S_ADD       = 3'd1,
    S_CMP       = 3'd2,
    S_BLINK     = 3'd3,
    S_SHOW_BEST = 3'd4
  } state_e;

  localparam int TMAX = (BLINK_HALF > BEST_HOLD) ? BLINK_HALF : BEST_HOLD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int HW   = $clog2(2 * BLINK_COUNT + 1);
  localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_HALF - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(2 * BLINK_COUNT - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(BEST_HOLD - 1);

  state_e        state_q;
  logic          get_q, lose_q;
  logic [15:0]   score_q, best_q, disp_q, work_q, addend_q;
  logic          blank_q, busy_q, game_over_q, new_best_q, nb_flag_q;
  logic          pend_q, carry_q;
  logic [3:0]    pend_spd_q;
  logic [1:0]    k_q;
  logic [TW-1:0] timer_q;
  logic [HW-1:0] half_q;

  logic          get_edge_d, lose_edge_d;
  logic [3:0]    add_spd_d;
  logic [4:0]    digit_d;
  logic [15:0]   work_d;

  // One BCD digit add; returns {carry_out, digit}. The 4-bit subtract wraps correctly for sums 10..19.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (sum > 5'd9) begin
      return {1'b1, sum[3:0] - 4'd10};
    end else begin
      return {1'b0, sum[3:0]};
    end
  endfunction

  function automatic logic [7:0] speed_to_bcd(input logic [3:0] spd);
    if (spd >= 4'd10) begin
      return {4'd1, spd - 4'd10};
    end else begin
      return {4'd0, spd};
    end
  endfunction

  // Edge detection and the current digit of the serial adder.
  always_comb begin
    get_edge_d  = get & ~get_q;
    lose_edge_d = lose & ~lose_q;
    add_spd_d   = pend_q ? pend_spd_q : bar_move_speed;
    digit_d     = bcd_digit_add(work_q[{k_q, 2'b00} +: 4], addend_q[{k_q, 2'b00} +: 4], carry_q);
    work_d      = work_q;
    work_d[{k_q, 2'b00} +: 4] = digit_d[3:0];
  end

  // Sequencer state, score registers and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PLAY;
      get_q       <= 1'b1;
      lose_q      <= 1'b1;
      score_q     <= 16'h0000;
      best_q      <= 16'h0000;
      disp_q      <= 16'h0000;
      work_q      <= 16'h0000;
      addend_q    <= 16'h0000;
      blank_q     <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      new_best_q  <= 1'b0;
      nb_flag_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_spd_q  <= 4'd0;
      carry_q     <= 1'b0;
      k_q         <= 2'd0;
      timer_q     <= '0;
      half_q      <= '0;
    end else begin
      get_q  <= get;
      lose_q <= lose;
      case (state_q)
        S_PLAY: begin
          if (lose_edge_d) begin
            state_q     <= S_CMP;
            pend_q      <= 1'b0;
            game_over_q <= 1'b1;
          end else if (pend_q || get_edge_d) begin
            // a queued catch takes precedence; a fresh edge in the same cycle is dropped
            state_q  <= S_ADD;
            work_q   <= score_q;
            addend_q <= {8'h00, speed_to_bcd(add_spd_d)};
            k_q      <= 2'd0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b1;
            pend_q   <= 1'b0;
          end
        end
        S_ADD: begin
          if (lose_edge_d) begin
            state_q     <= S_CMP;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            game_over_q <= 1'b1;
          end else begin
            if (get_edge_d && !pend_q) begin
              pend_q     <= 1'b1;
              pend_spd_q <= bar_move_speed;
            end
            work_q  <= work_d;
            carry_q <= digit_d[4];
            k_q     <= k_q + 2'd1;
            if (k_q == 2'd3) begin
              state_q <= S_PLAY;
              busy_q  <= 1'b0;
              score_q <= digit_d[4] ? 16'h9999 : work_d;
              disp_q  <= digit_d[4] ? 16'h9999 : work_d;
            end
          end
        end
        S_CMP: begin
          if (score_q > best_q) begin
            best_q    <= score_q;
            nb_flag_q <= 1'b1;
          end
          state_q <= S_BLINK;
          timer_q <= '0;
          half_q  <= '0;
          blank_q <= 1'b1;
        end
        S_BLINK: begin
          if (timer_q == BLINK_LAST) begin
            timer_q <= '0;
            if (half_q == HALF_LAST) begin
              state_q    <= S_SHOW_BEST;
              blank_q    <= 1'b0;
              disp_q     <= best_q;
              new_best_q <= nb_flag_q;
            end else begin
              half_q  <= half_q + HW'(1);
              blank_q <= ~blank_q;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_SHOW_BEST: begin
          if (timer_q == HOLD_LAST) begin
            timer_q     <= '0;
            state_q     <= S_PLAY;
            score_q     <= 16'h0000;
            disp_q      <= 16'h0000;
            nb_flag_q   <= 1'b0;
            new_best_q  <= 1'b0;
            game_over_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= S_PLAY;
        end
      endcase
    end
  end

  assign score       = score_q;
  assign best        = best_q;
  assign disp_digits = disp_q;
  assign disp_blank  = blank_q;
  assign busy        = busy_q;
  assign game_over   = game_over_q;
  assign new_best    = new_best_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench for score_display_ctrl: table of catch vectors with a commit
// scoreboard, plus hand-written game-over, pending-catch and reset-abort sequences.
module tb_score_display_ctrl;

  localparam int BH   = 4;
  localparam int BC   = 2;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst, get, lose;
  logic [3:0]  spd;
  logic [15:0] score, best, disp_digits;
  logic        disp_blank, busy, game_over, new_best;

  score_display_ctrl #(.BLINK_HALF(BH), .BLINK_COUNT(BC), .BEST_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .get(get), .lose(lose), .bar_move_speed(spd),
    .score(score), .best(best), .disp_digits(disp_digits), .disp_blank(disp_blank),
    .busy(busy), .game_over(game_over), .new_best(new_best)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] pre; logic [3:0] spd; logic [15:0] exp; } vec_t;
  typedef struct { logic [15:0] score; int at; } sb_t;

  sb_t         sb_q[$];
  vec_t        tbl[6];
  int          n_vec = 0;
  int          n_err = 0;
  int          model = 0;
  int          run_len = 0;
  bit          sb_en = 1'b1;
  bit          prev_busy = 1'b0;
  logic [15:0] model_best = 16'h0000;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [63:0] pack(input logic [15:0] s, input logic [15:0] b,
                                       input logic [15:0] d, input logic bl, input logic bu,
                                       input logic g, input logic n);
    return {8'h00, s, b, d, 4'h0, bl, bu, g, n};
  endfunction

  function automatic logic [63:0] obs();
    return pack(score, best, disp_digits, disp_blank, busy, game_over, new_best);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Commit check: a falling busy is the DUT presenting a finished addition.
  task automatic monitor();
    sb_t e;
    if (sb_en && prev_busy && !busy) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_commit at cycle %0d: got score %0h, expected no commit", cyc, score);
      end else begin
        e = sb_q.pop_front();
        check("commit_score", 64'(score), 64'(e.score));
        check("commit_cycle", 64'(cyc), 64'(e.at));
      end
      check("busy_len", 64'(run_len), 64'd4);
    end
    run_len   = busy ? run_len + 1 : 0;
    prev_busy = busy;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic catch_push(input logic [3:0] s, input logic [15:0] exp);
    spd = s;
    get = 1'b1;
    sb_q.push_back('{exp, cyc + 5});
    model = (model + int'(s) > 9999) ? 9999 : model + int'(s);
    tick();
    get = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check("commit_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic ramp_to(input int target);
    int step;
    while (model < target) begin
      step = (target - model > 15) ? 15 : target - model;
      catch_push(4'(step), to_bcd(model + step));
    end
  endtask

  task automatic go_seq(input logic [15:0] sc, input logic [15:0] eb, input logic enb,
                        input bit with_get, input bit get_in_blink);
    lose = 1'b1;
    if (with_get) begin
      get = 1'b1;
      spd = 4'd9;
    end
    tick();
    lose = 1'b0;
    get  = 1'b0;
    check("cmp_state", obs(), pack(sc, model_best, sc, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int t = 0; t < 2 * BC * BH; t++) begin
      tick();
      check("blink", obs(), pack(sc, eb, sc, ((t / BH) % 2) == 0, 1'b0, 1'b1, 1'b0));
      if (get_in_blink) get = (t == 5);
    end
    get = 1'b0;
    for (int u = 0; u < HOLD; u++) begin
      tick();
      check("show_best", obs(), pack(sc, eb, eb, 1'b0, 1'b0, 1'b1, enb));
    end
    tick();
    check("back_to_play", obs(), pack(16'h0000, eb, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
    model      = 0;
    model_best = eb;
  endtask

  initial begin
    tbl[0] = '{16'h0000, 4'd7,  16'h0007};
    tbl[1] = '{16'h0007, 4'd0,  16'h0007};
    tbl[2] = '{16'h0995, 4'd15, 16'h1010};
    tbl[3] = '{16'h1010, 4'd9,  16'h1019};
    tbl[4] = '{16'h9990, 4'd12, 16'h9999};
    tbl[5] = '{16'h9999, 4'd15, 16'h9999};

    rst  = 1'b1;
    get  = 1'b1;
    lose = 1'b0;
    spd  = 4'd0;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_get_held", obs(), 64'd0);
    end
    get = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      ramp_to(bcd2int(tbl[i].pre));
      check("pre_score", 64'(score), 64'(tbl[i].pre));
      catch_push(tbl[i].spd, tbl[i].exp);
    end

    // reset in the middle of an addition
    sb_en = 1'b0;
    spd = 4'd4;
    get = 1'b1;
    tick();
    get = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_add", obs(), 64'd0);
    rst = 1'b0;
    tick();
    check("after_rst_add", obs(), 64'd0);
    model = 0;
    sb_en = 1'b1;

    // pending catch, and a third edge inside the same ADD that must be dropped
    spd = 4'd3;
    get = 1'b1;
    sb_q.push_back('{16'h0003, cyc + 5});
    tick();
    get = 1'b0;
    tick();
    spd = 4'd5;
    get = 1'b1;
    sb_q.push_back('{16'h0008, cyc + 8});
    tick();
    get = 1'b0;
    tick();
    spd = 4'd7;
    get = 1'b1;
    tick();
    get = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check("pending_timeout", 64'(sb_q.size()), 64'd0);
    repeat (10) tick();
    check("third_dropped", obs(), pack(16'h0008, 16'h0000, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0));
    model = 8;

    ramp_to(30);
    go_seq(16'h0030, 16'h0030, 1'b1, 1'b0, 1'b0);
    ramp_to(42);
    go_seq(16'h0042, 16'h0042, 1'b1, 1'b1, 1'b0);
    ramp_to(10);
    go_seq(16'h0010, 16'h0042, 1'b0, 1'b0, 1'b1);
    repeat (6) tick();
    check("blink_get_ignored", obs(), pack(16'h0000, 16'h0042, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));

    // reset in the middle of the blink phase
    ramp_to(5);
    lose = 1'b1;
    tick();
    lose = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_blink", obs(), 64'd0);
    rst = 1'b0;
    tick();
    check("after_rst_blink", obs(), 64'd0);
    model = 0;

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
